// File: rtl/int_ram_pkg.sv
// rtl/int_ram_pkg.sv - shared types and sizing helpers for the intrinsic LLR ring buffer
package int_ram_pkg;

    localparam int LLR_W = 8;

    typedef logic [LLR_W-1:0] llr_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/int_frame_bank.sv
// rtl/int_frame_bank.sv - single-port synchronous-read frame RAM with chip select
module int_frame_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  cs_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (cs_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/int_ram_ring.sv
// rtl/int_ram_ring.sv - N-frame intrinsic LLR ring: streaming fill, random-access decode read
module int_ram_ring
    import int_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 256,
    parameter int NUM_FRAMES = 2,
    localparam int IDX_W = idx_width(NUM_FRAMES),
    localparam int CNT_W = cnt_width(NUM_FRAMES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_flush,
    output logic                  dec_avail,
    output logic [IDX_W-1:0]      dec_frame_idx,
    input  logic                  dec_rd_en,
    input  logic [ADDR_WIDTH-1:0] dec_rd_addr,
    output logic [DATA_WIDTH-1:0] dec_rd_data,
    output logic                  dec_rd_valid,
    input  logic                  dec_release,
    output logic [CNT_W-1:0]      frames_full
);

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_FRAMES - 1);

    logic [IDX_W-1:0]      fill_ptr_q, fill_ptr_d;
    logic [IDX_W-1:0]      dec_ptr_q, dec_ptr_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]      full_cnt_q, full_cnt_d;
    logic                  rd_valid_q, rd_oob_q, rd_live_q;
    logic [IDX_W-1:0]      rd_bank_q;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_FRAMES];

    logic wr_fire, frame_done, rd_fire, rd_oob, rel_fire;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign ld_ready      = full_cnt_q < CNT_W'(NUM_FRAMES);
    assign dec_avail     = full_cnt_q != '0;
    assign dec_frame_idx = dec_ptr_q;
    assign frames_full   = full_cnt_q;
    assign dec_rd_valid  = rd_valid_q;

    assign wr_fire    = ld_valid & ld_ready & ~ld_flush;
    assign frame_done = wr_fire & (word_cnt_q == LAST_WORD);
    assign rd_fire    = dec_rd_en & dec_avail;
    assign rd_oob     = {1'b0, dec_rd_addr} >= (ADDR_WIDTH + 1)'(FRAME_LEN);
    assign rel_fire   = dec_release & dec_avail;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (ld_flush) begin
            word_cnt_d = '0;
        end else if (wr_fire) begin
            word_cnt_d = frame_done ? '0 : word_cnt_q + 1'b1;
        end
        fill_ptr_d = frame_done ? ptr_inc(fill_ptr_q) : fill_ptr_q;
        dec_ptr_d  = rel_fire ? ptr_inc(dec_ptr_q) : dec_ptr_q;
        full_cnt_d = full_cnt_q;
        case ({frame_done, rel_fire})
            2'b10:   full_cnt_d = full_cnt_q + 1'b1;
            2'b01:   full_cnt_d = full_cnt_q - 1'b1;
            default: full_cnt_d = full_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_ptr_q <= '0;
            dec_ptr_q  <= '0;
            word_cnt_q <= '0;
            full_cnt_q <= '0;
        end else begin
            fill_ptr_q <= fill_ptr_d;
            dec_ptr_q  <= dec_ptr_d;
            word_cnt_q <= word_cnt_d;
            full_cnt_q <= full_cnt_d;
        end
    end

    // Bank read registers only update on a read, so the selected word holds between reads;
    // rd_live_q masks the unreset bank output until the first read after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            rd_live_q  <= 1'b0;
            rd_bank_q  <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_bank_q <= dec_ptr_q;
                rd_oob_q  <= rd_oob;
                rd_live_q <= 1'b1;
            end
        end
    end

    assign dec_rd_data = (rd_live_q && !rd_oob_q) ? bank_rdata[rd_bank_q] : '0;

    for (genvar b = 0; b < NUM_FRAMES; b++) begin : g_bank
        logic wr_sel, rd_sel;
        assign wr_sel = wr_fire && (fill_ptr_q == IDX_W'(b));
        assign rd_sel = rd_fire && !rd_oob && (dec_ptr_q == IDX_W'(b));

        int_frame_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk     (clk),
            .cs_i    (wr_sel | rd_sel),
            .we_i    (wr_sel),
            .addr_i  (wr_sel ? word_cnt_q : dec_rd_addr),
            .wdata_i (ld_data),
            .rdata_o (bank_rdata[b])
        );
    end

endmodule

// File: tb/tb_int_ram_ring.sv
// tb/tb_int_ram_ring.sv - scoreboard bench for int_ram_ring against a frame-queue model
module tb_int_ram_ring;
    import int_ram_pkg::*;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int FL = 4;
    localparam int NF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_flush, dec_rd_en, dec_release;
    llr_t          ld_data;
    logic [AW-1:0] dec_rd_addr;
    logic          ld_ready, dec_avail, dec_rd_valid;
    logic [0:0]    dec_frame_idx;
    logic [DW-1:0] dec_rd_data;
    logic [1:0]    frames_full;

    int_ram_ring #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FRAME_LEN  (FL),
        .NUM_FRAMES (NF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_data       (ld_data),
        .ld_flush      (ld_flush),
        .dec_avail     (dec_avail),
        .dec_frame_idx (dec_frame_idx),
        .dec_rd_en     (dec_rd_en),
        .dec_rd_addr   (dec_rd_addr),
        .dec_rd_data   (dec_rd_data),
        .dec_rd_valid  (dec_rd_valid),
        .dec_release   (dec_release),
        .frames_full   (frames_full)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: complete frames in arrival order, the partially loaded frame, and releases seen.
    logic [8*FL-1:0] full_q [$];
    logic [7:0]      part_q [$];
    int              rel_count = 0;
    logic [7:0]      exp_q [$];
    logic [7:0]      hold_exp = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_state();
        chk("ld_ready", 32'(ld_ready), 32'(full_q.size() < NF));
        chk("dec_avail", 32'(dec_avail), 32'(full_q.size() != 0));
        chk("frames_full", 32'(frames_full), 32'(full_q.size()));
        chk("dec_frame_idx", 32'(dec_frame_idx), 32'(rel_count % NF));
    endtask

    task automatic model_reset();
        full_q.delete();
        part_q.delete();
        exp_q.delete();
        rel_count = 0;
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit fl,
                         input bit re, input logic [AW-1:0] a, input bit rel);
        logic [8*FL-1:0] f;
        bit rdy, avail;
        ld_valid = v; ld_data = d; ld_flush = fl;
        dec_rd_en = re; dec_rd_addr = a; dec_release = rel;
        chk_state();
        rdy   = full_q.size() < NF;
        avail = full_q.size() != 0;
        if (re && avail) begin
            f = full_q[0];
            exp_q.push_back((int'(a) >= FL) ? 8'h00 : f[int'(a)*8 +: 8]);
        end
        if (rel && avail) begin
            void'(full_q.pop_front());
            rel_count++;
        end
        if (fl) begin
            part_q.delete();
        end else if (v && rdy) begin
            part_q.push_back(d);
            if (part_q.size() == FL) begin
                for (int i = 0; i < FL; i++) f[i*8 +: 8] = part_q[i];
                full_q.push_back(f);
                part_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, a, 1'b0);
    endtask

    task automatic release_frame();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_exp = '0;
        end else if (dec_rd_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rd_unexpected: got valid data %0h expected no read at %0t",
                         dec_rd_data, $time);
            end else begin
                hold_exp = exp_q.pop_front();
                chk("rd_data", 32'(dec_rd_data), 32'(hold_exp));
            end
        end else begin
            chk("rd_hold", 32'(dec_rd_data), 32'(hold_exp));
        end
    end

    initial begin
        rst = 1'b1;
        ld_valid = 0; ld_data = '0; ld_flush = 0;
        dec_rd_en = 0; dec_rd_addr = '0; dec_release = 0;
        #12;
        chk("rst_rd_valid", 32'(dec_rd_valid), 32'd0);
        chk("rst_rd_data", 32'(dec_rd_data), 32'd0);
        chk_state();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 1; i <= 4; i++) load(8'(i));
        for (int a = 0; a < 4; a++) rd(AW'(a));
        idle();

        for (int i = 5; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1, AW'(2), 1'b0);
        for (int i = 0; i < 3; i++) load(8'h99);

        release_frame();
        for (int i = 9; i <= 12; i++) load(8'(i));
        release_frame();
        for (int a = 0; a < 4; a++) rd(AW'(a));

        for (int i = 30; i <= 32; i++) load(8'(i));
        cycle(1'b0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 20; i <= 23; i++) load(8'(i));
        release_frame();
        for (int a = 0; a < 4; a++) rd(AW'(a));
        release_frame();
        for (int i = 60; i <= 62; i++) load(8'(i));
        cycle(1'b1, 8'd63, 1'b1, 1'b0, '0, 1'b0);
        idle();

        for (int i = 40; i <= 43; i++) load(8'(i));
        for (int i = 50; i <= 52; i++) load(8'(i));
        cycle(1'b1, 8'd53, 1'b0, 1'b0, '0, 1'b1);
        for (int a = 0; a < 4; a++) rd(AW'(a));
        release_frame();

        cycle(1'b0, 8'h00, 1'b0, 1'b1, AW'(1), 1'b1);
        idle();
        for (int i = 70; i <= 73; i++) load(8'(i));
        rd(AW'(7));
        rd(AW'(3));
        idle();

        load(8'd80);
        load(8'd81);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_rd_valid", 32'(dec_rd_valid), 32'd0);
        chk("mid_rst_rd_data", 32'(dec_rd_data), 32'd0);
        model_reset();
        chk_state();
        ld_valid = 0; ld_flush = 0; dec_rd_en = 0; dec_release = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
                  ($urandom_range(0, 6) == 0));
        end
        repeat (3) idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
